// File: rtl/wb_regfile.sv
// Sixteen-entry register file with write-back port, two combinational read ports and per-register in-flight scoreboard.
// Optional WB_BYPASS_EN forwards the same-cycle write-back to both read ports and to the hazard check.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_i,
  input  logic [3:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [3:0]        rd_addr_i,
  input  logic [3:0]        rs_addr_i,
  input  logic              rd_en_i,
  input  logic              rs_en_i,
  output logic [DATA_W-1:0] rd_value_o,
  output logic [DATA_W-1:0] rs_value_o,
  input  logic              issue_i,
  input  logic [3:0]        issue_rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [15:0]       pending_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [16];
  logic [CNT_W-1:0]  cnt  [16];
  logic [15:0]       busy;
  logic              issue_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 16; n++) regs[n] <= '0;
    end else if (wb_en_i) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    busy = '0;
    for (int n = 0; n < 16; n++) begin
      busy[n] = (cnt[n] != '0);
`ifdef WB_BYPASS_EN
      // The last outstanding write lands this cycle and is forwarded, so no wait.
      if (cnt[n] == CNT_ONE && wb_en_i && wb_addr_i == 4'(n)) busy[n] = 1'b0;
`endif
    end
  end

  always_comb begin
    stall_o = (rd_en_i & busy[rd_addr_i]) |
              (rs_en_i & busy[rs_addr_i]) |
              (issue_i & (cnt[issue_rd_i] == CNT_MAX));
    issue_acc = issue_i & ~stall_o & ~flush_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 16; n++) cnt[n] <= '0;
    end else if (flush_i) begin
      for (int n = 0; n < 16; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 16; n++) begin
        // Increment cannot overflow: an issue to a saturated counter stalls.
        if (issue_acc && issue_rd_i == 4'(n)) begin
          if (!(wb_en_i && wb_addr_i == 4'(n))) cnt[n] <= cnt[n] + CNT_ONE;
        end else if (wb_en_i && wb_addr_i == 4'(n) && cnt[n] != '0) begin
          cnt[n] <= cnt[n] - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 16; n++) pending_o[n] = (cnt[n] != '0);
  end

`ifdef WB_BYPASS_EN
  assign rd_value_o = (wb_en_i && wb_addr_i == rd_addr_i) ? wb_data_i : regs[rd_addr_i];
  assign rs_value_o = (wb_en_i && wb_addr_i == rs_addr_i) ? wb_data_i : regs[rs_addr_i];
`else
  assign rd_value_o = regs[rd_addr_i];
  assign rs_value_o = regs[rs_addr_i];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile; expectations follow the WB_BYPASS_EN setting of the build.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [3:0]  rd_addr_i;
  logic [3:0]  rs_addr_i;
  logic        rd_en_i;
  logic        rs_en_i;
  logic [31:0] rd_value_o;
  logic [31:0] rs_value_o;
  logic        issue_i;
  logic [3:0]  issue_rd_i;
  logic        flush_i;
  logic        stall_o;
  logic [15:0] pending_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_regfile #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rd_addr_i(rd_addr_i), .rs_addr_i(rs_addr_i),
    .rd_en_i(rd_en_i), .rs_en_i(rs_en_i),
    .rd_value_o(rd_value_o), .rs_value_o(rs_value_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0;
    rd_addr_i = 0; rs_addr_i = 0; rd_en_i = 0; rs_en_i = 0;
    issue_i = 0; issue_rd_i = 0; flush_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h expected 0000", pending_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    n_checks++; if (rd_value_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd_value: got %h expected 0", rd_value_o); end
    cycle();
    wb_en_i = 1; wb_addr_i = 3; wb_data_i = 32'h1234;
    cycle();
    idle();
    issue_i = 1; issue_rd_i = 3;
    cycle();
    idle();
    rd_addr_i = 3; rs_addr_i = 3;
    #1;
    n_checks++; if (rd_value_o !== 32'h1234) begin n_fail++; $display("FAIL pre_reset_r3: got %h expected 00001234", rd_value_o); end
    n_checks++; if (pending_o !== 16'h0008) begin n_fail++; $display("FAIL pre_reset_pending: got %h expected 0008", pending_o); end
    #2 rst = 1;
    #1;
    n_checks++; if (rd_value_o !== 32'h0) begin n_fail++; $display("FAIL async_reset_r3: got %h expected 0", rd_value_o); end
    n_checks++; if (rs_value_o !== 32'h0) begin n_fail++; $display("FAIL async_reset_rs: got %h expected 0", rs_value_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL async_reset_pending: got %h expected 0000", pending_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_stall: got %b expected 0", stall_o); end
    cycle();
    rst = 0;
    cycle();
  endtask

  task automatic test_write_read();
    idle();
    wb_en_i = 1; wb_addr_i = 5; wb_data_i = 32'hDEADBEEF;
    rd_addr_i = 5;
    #1;
    n_checks++;
    if (rd_value_o !== (BYP ? 32'hDEADBEEF : 32'h0)) begin
      n_fail++; $display("FAIL same_cycle_read_r5: got %h expected %h", rd_value_o, BYP ? 32'hDEADBEEF : 32'h0);
    end
    cycle();
    idle();
    rd_addr_i = 5; rs_addr_i = 5;
    #1;
    n_checks++; if (rd_value_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_r5_rd: got %h expected deadbeef", rd_value_o); end
    n_checks++; if (rs_value_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_r5_rs: got %h expected deadbeef", rs_value_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL wb_no_underflow: got %h expected 0000", pending_o); end
    cycle();
  endtask

  task automatic test_raw_hazard();
    idle();
    issue_i = 1; issue_rd_i = 2;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall: got %b expected 0", stall_o); end
    cycle();
    idle();
    rd_en_i = 1; rd_addr_i = 2;
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b expected 1", stall_o); end
    n_checks++; if (pending_o !== 16'h0004) begin n_fail++; $display("FAIL raw_pending: got %h expected 0004", pending_o); end
    cycle();
    wb_en_i = 1; wb_addr_i = 2; wb_data_i = 32'd7;
    #1;
    n_checks++;
    if (stall_o !== (BYP ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL raw_wb_cycle_stall: got %b expected %b", stall_o, !BYP); end
    n_checks++;
    if (rd_value_o !== (BYP ? 32'd7 : 32'd0)) begin n_fail++; $display("FAIL raw_wb_cycle_value: got %h expected %h", rd_value_o, BYP ? 32'd7 : 32'd0); end
    cycle();
    wb_en_i = 0;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb_stall: got %b expected 0", stall_o); end
    n_checks++; if (rd_value_o !== 32'd7) begin n_fail++; $display("FAIL raw_after_wb_value: got %h expected 7", rd_value_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL raw_after_wb_pending: got %h expected 0000", pending_o); end
    idle();
    cycle();
  endtask

  task automatic test_saturation();
    idle();
    for (int i = 0; i < 3; i++) begin
      issue_i = 1; issue_rd_i = 4;
      #1;
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL sat_issue%0d_stall: got %b expected 0", i, stall_o); end
      cycle();
    end
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL sat_fourth_stall: got %b expected 1", stall_o); end
    n_checks++; if (pending_o !== 16'h0010) begin n_fail++; $display("FAIL sat_pending: got %h expected 0010", pending_o); end
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      wb_en_i = 1; wb_addr_i = 4; wb_data_i = 32'h40 + i;
      cycle();
      wb_en_i = 0;
      #1;
      n_checks++;
      if (pending_o[4] !== (i < 2)) begin n_fail++; $display("FAIL sat_drain%0d_pending4: got %b expected %b", i, pending_o[4], i < 2); end
    end
    rd_addr_i = 4;
    #1;
    n_checks++; if (rd_value_o !== 32'h42) begin n_fail++; $display("FAIL sat_r4_value: got %h expected 00000042", rd_value_o); end
    idle();
    cycle();
  endtask

  task automatic test_simultaneous();
    idle();
    issue_i = 1; issue_rd_i = 6;
    cycle();
    wb_en_i = 1; wb_addr_i = 6; wb_data_i = 32'h66;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL simul_stall: got %b expected 0", stall_o); end
    cycle();
    idle();
    rd_addr_i = 6;
    #1;
    n_checks++; if (pending_o !== 16'h0040) begin n_fail++; $display("FAIL simul_pending: got %h expected 0040", pending_o); end
    n_checks++; if (rd_value_o !== 32'h66) begin n_fail++; $display("FAIL simul_value: got %h expected 00000066", rd_value_o); end
    wb_en_i = 1; wb_addr_i = 6; wb_data_i = 32'h67;
    cycle();
    idle();
    #1;
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL simul_drain_pending: got %h expected 0000", pending_o); end
    cycle();
  endtask

  task automatic test_flush();
    idle();
    issue_i = 1; issue_rd_i = 1;
    cycle();
    issue_rd_i = 9;
    cycle();
    idle();
    #1;
    n_checks++; if (pending_o !== 16'h0202) begin n_fail++; $display("FAIL flush_pre_pending: got %h expected 0202", pending_o); end
    flush_i = 1; issue_i = 1; issue_rd_i = 10;
    wb_en_i = 1; wb_addr_i = 9; wb_data_i = 32'h99;
    cycle();
    idle();
    rd_addr_i = 9;
    #1;
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL flush_pending: got %h expected 0000", pending_o); end
    n_checks++; if (rd_value_o !== 32'h99) begin n_fail++; $display("FAIL flush_same_cycle_wb: got %h expected 00000099", rd_value_o); end
    wb_en_i = 1; wb_addr_i = 1; wb_data_i = 32'h11;
    cycle();
    idle();
    rd_addr_i = 1;
    #1;
    n_checks++; if (rd_value_o !== 32'h11) begin n_fail++; $display("FAIL flush_late_wb_value: got %h expected 00000011", rd_value_o); end
    n_checks++; if (pending_o !== 16'h0000) begin n_fail++; $display("FAIL flush_late_wb_pending: got %h expected 0000", pending_o); end
    cycle();
  endtask

  initial begin
    rst = 1;
    idle();
    #2;
    test_reset();
    test_write_read();
    test_raw_hazard();
    test_saturation();
    test_simultaneous();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
